// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_if_pkg
//  Purpose  : Shared types for the memory request interface. The request
//             generator and the memory responder both use this package.
//  Revision : 1.0  initial release
// ============================================================================
package mem_if_pkg;

    // Default bus widths used by the interface and the responder
    localparam int c_addr_w_def = 16;
    localparam int c_data_w_def = 16;

    // Responder lifecycle: clear the store first, then serve requests
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One request as seen by generator and responder
    typedef struct packed {
        logic [c_addr_w_def-1:0] addr;
        logic [c_data_w_def-1:0] data;
    } req_t;

endpackage : mem_if_pkg
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder_if
//  Purpose  : Memory request/return bus. The master modport is the request
//             generator side. The slave modport is the responder side.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_responder_if
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_def,
    parameter int DATA_W = c_data_w_def
) ();

    // Write request channel
    logic [ADDR_W-1:0] wr_address;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    // Write return channel
    logic [ADDR_W-1:0] wr_ret_address;
    logic              wr_ret_ack;

    // Read request channel
    logic [ADDR_W-1:0] rd_address;
    logic              rd_en;

    // Read return channel
    logic [DATA_W-1:0] rd_ret_data;
    logic [ADDR_W-1:0] rd_ret_address;
    logic              rd_ret_ack;

    // Responder ready indication
    logic              init_done;

    modport master (
        output wr_address, wr_en, wr_data, rd_address, rd_en,
        input  wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address,
               rd_ret_ack, init_done
    );

    modport slave (
        input  wr_address, wr_en, wr_data, rd_address, rd_en,
        output wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address,
               rd_ret_ack, init_done
    );

endinterface : mem_responder_if
`default_nettype wire

// File: rtl/mem_resp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mem_resp_pipe
//  Purpose  : Fixed-depth valid+payload shift register. The valid bit moves
//             one stage every clock. A payload stage is loaded only when a
//             valid word enters it, so the tail keeps its last delivered
//             payload between pulses.
//  Revision : 1.0  initial release
// ============================================================================
module mem_resp_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             valid_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o
);

    // Stage s reads from index s and drives index s+1. Index 0 is the input.
    logic [DEPTH:0]   w_valid;
    logic [WIDTH-1:0] w_data [DEPTH+1];

    assign w_valid[0] = valid_i;
    assign w_data[0]  = data_i;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        // Advance valid every cycle; advance payload only with a valid word
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= w_valid[s];
                if (w_valid[s]) begin
                    data_q <= w_data[s];
                end
            end
        end

        assign w_valid[s+1] = valid_q;
        assign w_data[s+1]  = data_q;
    end : g_stage

    assign valid_o = w_valid[DEPTH];
    assign data_o  = w_data[DEPTH];

endmodule : mem_resp_pipe
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Memory endpoint for the request interface. It accepts one write
//             and one read per cycle into a word-addressed store. It returns
//             in-order write and read acks after WR_LAT and RD_LAT clocks.
//             After reset, the store is cleared once (INIT) and then requests
//             are served (RUN).
//  Options  : MEM_RESP_STATS_EN adds 32-bit wr_count / rd_count ack counters.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w_def,
    parameter int DATA_W     = c_data_w_def,
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
`ifdef MEM_RESP_STATS_EN
    output logic [31:0]      wr_count,
    output logic [31:0]      rd_count,
`endif
    mem_responder_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // ------------------------------------------------------------------
    // State, clear counter and store
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic [DEPTH_LOG2-1:0]   clear_cnt_q;
    logic [DEPTH_LOG2-1:0]   clear_cnt_d;
    logic                    init_done_q;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                    w_run;
    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic [DEPTH_LOG2-1:0]   w_wr_idx;
    logic [DEPTH_LOG2-1:0]   w_rd_idx;
    logic [DATA_W-1:0]       w_rd_data;

    assign clear_cnt_d = clear_cnt_q + 1'b1;

    // Requests seen outside RUN are dropped without a trace
    assign w_run       = (state_q == ST_RUN);
    assign w_wr_accept = w_run & bus.wr_en;
    assign w_rd_accept = w_run & bus.rd_en;

    // Upper address bits alias onto the same store word
    assign w_wr_idx    = bus.wr_address[DEPTH_LOG2-1:0];
    assign w_rd_idx    = bus.rd_address[DEPTH_LOG2-1:0];

    // Write-first: a read of the word being written this cycle sees the new data
    assign w_rd_data   = (w_wr_accept && (w_wr_idx == w_rd_idx)) ? bus.wr_data
                                                                 : mem_q[w_rd_idx];

    // Lifecycle FSM: walk the clear counter across the store, then serve
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clear_cnt_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    clear_cnt_q <= clear_cnt_d;
                    if (clear_cnt_q == {DEPTH_LOG2{1'b1}}) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_INIT;
                    clear_cnt_q <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Store write port: clearing during INIT, accepted writes during RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_q[clear_cnt_q] <= '0;
            end else if (w_wr_accept) begin
                mem_q[w_wr_idx] <= bus.wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture stage: sample request and read snapshot at the accepting edge
    // ------------------------------------------------------------------
    logic                       wr_cap_vld_q;
    logic [ADDR_W-1:0]          wr_cap_addr_q;
    logic                       rd_cap_vld_q;
    logic [ADDR_W+DATA_W-1:0]   rd_cap_q;

    // Snapshot both channels; the pipes below add the remaining latency
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cap_vld_q  <= 1'b0;
            wr_cap_addr_q <= '0;
            rd_cap_vld_q  <= 1'b0;
            rd_cap_q      <= '0;
        end else begin
            wr_cap_vld_q  <= w_wr_accept;
            wr_cap_addr_q <= bus.wr_address;
            rd_cap_vld_q  <= w_rd_accept;
            rd_cap_q      <= {bus.rd_address, w_rd_data};
        end
    end

    // ------------------------------------------------------------------
    // Latency pipes. The capture register is one stage, so each pipe is
    // LAT deep and its tail lands on edge k+LAT.
    // ------------------------------------------------------------------
    logic                       w_wr_ack;
    logic [ADDR_W-1:0]          w_wr_ret_addr;
    logic                       w_rd_ack;
    logic [ADDR_W+DATA_W-1:0]   w_rd_ret;

    mem_resp_pipe #(
        .DEPTH (WR_LAT),
        .WIDTH (ADDR_W)
    ) u_wr_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (wr_cap_vld_q),
        .data_i  (wr_cap_addr_q),
        .valid_o (w_wr_ack),
        .data_o  (w_wr_ret_addr)
    );

    mem_resp_pipe #(
        .DEPTH (RD_LAT),
        .WIDTH (ADDR_W + DATA_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_cap_vld_q),
        .data_i  (rd_cap_q),
        .valid_o (w_rd_ack),
        .data_o  (w_rd_ret)
    );

    assign bus.wr_ret_ack     = w_wr_ack;
    assign bus.wr_ret_address = w_wr_ret_addr;
    assign bus.rd_ret_ack     = w_rd_ack;
    assign bus.rd_ret_address = w_rd_ret[ADDR_W+DATA_W-1:DATA_W];
    assign bus.rd_ret_data    = w_rd_ret[DATA_W-1:0];
    assign bus.init_done      = init_done_q;

`ifdef MEM_RESP_STATS_EN
    // ------------------------------------------------------------------
    // Ack counters, free-running modulo 2^32
    // ------------------------------------------------------------------
    logic [31:0] wr_count_q;
    logic [31:0] rd_count_q;

    // Count each ack pulse on both return channels
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if (w_wr_ack) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (w_rd_ack) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`endif

endmodule : mem_responder
`default_nettype wire
